// File: rtl/sqrt_share_arbiter_pkg.sv
// Shared constants and FSM encoding for the shared square-root arbiter.
package sqrt_share_arbiter_pkg;

  localparam int F32W = 32;
  localparam logic [F32W-1:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/sqrt_share_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  idx,
  output logic            any_req
);

  localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

  logic [IDW:0] pos;

  always_comb begin
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    pos     = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos = {1'b0, ptr} + (IDW+1)'(k);
      if (pos >= NREQ_W) pos = pos - NREQ_W;
      if (!any_req && req[pos[IDW-1:0]]) begin
        any_req             = 1'b1;
        gnt[pos[IDW-1:0]]   = 1'b1;
        idx                 = pos[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/sqrt_share_arbiter.sv
// Time-shares one external bit-serial sqrt unit among NREQ requesters with a
// watchdog and a registered result buffer held until the consumer accepts it.
module sqrt_share_arbiter
  import sqrt_share_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*32-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  output logic                 res_valid,
  output logic [31:0]          res_data,
  output logic [IDW-1:0]       res_id,
  output logic                 res_err,
  input  logic                 res_ready,
  output logic                 busy,
  output logic                 sq_rst,
  output logic [31:0]          sq_a,
  input  logic                 sq_rdy,
  input  logic [31:0]          sq_result
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  TO_CNT  = CW'(TIMEOUT);
  localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

  state_t            state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [IDW-1:0]    id_q, id_d;
  logic [F32W-1:0]   sq_a_q, sq_a_d;
  logic [F32W-1:0]   res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              res_vld_q, res_vld_d;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    win_idx;
  logic              win_any;
  logic [F32W-1:0]   win_op;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .req     (req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .idx     (win_idx),
    .any_req (win_any)
  );

  always_comb win_op = req_data[win_idx*F32W +: F32W];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    sq_a_d     = sq_a_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    res_vld_d  = res_vld_q;
    req_ready  = '0;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          req_ready = gnt;
          sq_a_d    = win_op;
          id_d      = win_idx;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        // sq_rdy is stale here: it still reflects the previous operation
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (sq_rdy) begin
          res_data_d = sq_result;
          res_err_d  = 1'b0;
          res_vld_d  = 1'b1;
          state_d    = ST_RESP;
        end else if (cnt_q == TO_CNT) begin
          res_data_d = QNAN;
          res_err_d  = 1'b1;
          res_vld_d  = 1'b1;
          state_d    = ST_RESP;
        end
      end
      ST_RESP: begin
        if (res_ready) begin
          res_vld_d = 1'b0;
          ptr_d     = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      id_q       <= '0;
      sq_a_q     <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
      res_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      id_q       <= id_d;
      sq_a_q     <= sq_a_d;
      res_data_q <= res_data_d;
      res_err_q  <= res_err_d;
      res_vld_q  <= res_vld_d;
    end
  end

  assign res_valid = res_vld_q;
  assign res_data  = res_data_q;
  assign res_id    = id_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign sq_rst    = (state_q == ST_START);
  assign sq_a      = sq_a_q;

endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// Randomized bench for sqrt_share_arbiter with a stub sqrt unit of controllable latency.
module tb_sqrt_share_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int TIMEOUT = 31;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ*32-1:0]  req_data;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic [31:0]         res_data;
  logic [IDW-1:0]      res_id;
  logic                res_err;
  logic                res_ready;
  logic                busy;
  logic                sq_rst;
  logic [31:0]         sq_a;
  logic                sq_rdy;
  logic [31:0]         sq_result;

  logic [31:0]         rop [NREQ];

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NREQ; i++) req_data[32*i +: 32] = rop[i];
  end

  sqrt_share_arbiter #(.NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_err   (res_err),
    .res_ready (res_ready),
    .busy      (busy),
    .sq_rst    (sq_rst),
    .sq_a      (sq_a),
    .sq_rdy    (sq_rdy),
    .sq_result (sq_result)
  );

  function automatic logic [31:0] ref_sqrt(logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0000_0000;
      32'h3F80_0000: return 32'h3F80_0000;
      32'h4080_0000: return 32'h4000_0000;
      32'h4110_0000: return 32'h4040_0000;
      default:       return a ^ 32'h0F0F_1234;
    endcase
  endfunction

  // Stub sqrt unit: rdy drops on the start pulse and rises stub_lat cycles later.
  int   stub_lat;
  logic stuck;
  int   stub_cnt;
  always @(posedge clk) begin
    if (rst) begin
      sq_rdy    <= 1'b1;
      sq_result <= 32'h1111_1111;
      stub_cnt  <= 0;
    end else if (sq_rst) begin
      stub_cnt  <= stub_lat;
      sq_rdy    <= (stub_lat == 0) && !stuck;
      sq_result <= ref_sqrt(sq_a);
    end else if (!sq_rdy && !stuck && stub_cnt > 0) begin
      if (stub_cnt == 1) sq_rdy <= 1'b1;
      stub_cnt <= stub_cnt - 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  int          cyc = 0;
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_id, m_acc, m_lat;
  bit          m_stk;
  logic [31:0] m_op;
  int          next_lat = 0;
  bit          next_stuck = 0;
  bit          rr_rand = 0;
  int          hold_cnt = 0;
  int          grant_log[$];

  function automatic int rr_pick(logic [NREQ-1:0] v, int p);
    for (int k = 0; k < NREQ; k++) begin
      int i;
      i = (p + k) % NREQ;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  function automatic int t_result();
    return m_acc + 3 + (m_stk ? TIMEOUT : m_lat);
  endfunction

  task automatic model_check(output int acc);
    acc = -1;
    chk("busy", 32'(busy), 32'(m_busy));
    if (!m_busy) begin
      int w;
      logic [NREQ-1:0] eg;
      w  = rr_pick(req_valid, m_ptr);
      eg = '0;
      if (w >= 0) eg[w] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(eg));
      chk("res_valid_idle", 32'(res_valid), 32'd0);
      chk("sq_rst_idle", 32'(sq_rst), 32'd0);
      if (w >= 0) begin
        m_busy = 1; m_id = w; m_op = rop[w]; m_acc = cyc;
        m_lat = next_lat; m_stk = next_stuck;
        stub_lat = next_lat; stuck = next_stuck;
        grant_log.push_back(w);
        acc = w;
      end
    end else begin
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      chk("sq_rst", 32'(sq_rst), 32'(cyc == m_acc + 1));
      chk("sq_a", sq_a, m_op);
      chk("res_valid", 32'(res_valid), 32'(cyc >= t_result()));
      if (cyc >= t_result()) begin
        chk("res_data", res_data, m_stk ? 32'h7FC0_0000 : ref_sqrt(m_op));
        chk("res_id", 32'(res_id), 32'(m_id));
        chk("res_err", 32'(res_err), 32'(m_stk));
        if (res_ready) begin
          m_busy = 0;
          m_ptr  = (m_id + 1) % NREQ;
        end
      end
    end
  endtask

  task automatic step();
    int acc;
    @(negedge clk);
    model_check(acc);
    @(posedge clk);
    cyc++;
    #1;
    if (acc >= 0) req_valid[acc] = 1'b0;
    if (hold_cnt > 0) begin
      res_ready = 1'b0;
      if (m_busy && cyc >= t_result()) hold_cnt--;
    end else begin
      res_ready = rr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((m_busy || req_valid != '0) && n < budget) begin
      step();
      n++;
    end
    chk("drain_done", 32'(m_busy || req_valid != '0), 32'd0);
  endtask

  task automatic send(input int id, input logic [31:0] op);
    rop[id] = op;
    req_valid[id] = 1'b1;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 4))
      0: return 32'h0000_0000;
      1: return 32'h4080_0000;
      2: return 32'h4110_0000;
      3: return 32'h3F80_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; req_valid = '0; res_ready = 1'b0;
    stub_lat = 0; stuck = 1'b0;
    for (int i = 0; i < NREQ; i++) rop[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_sq_rst", 32'(sq_rst), 32'd0);
    chk("rst_res_data", res_data, 32'd0);
    chk("rst_res_id", 32'(res_id), 32'd0);
    chk("rst_sq_a", sq_a, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; res_ready = 1'b1;

    // All four at once: order 0,1,2,3 and the pointer wraps back to 0
    next_lat = 7;
    for (int i = 0; i < NREQ; i++) send(i, 32'h4110_0000);
    drain(400);
    for (int i = 0; i < NREQ; i++)
      chk("grant_order", 32'(grant_log[i]), 32'(i));
    chk("ptr_wrap", 32'(m_ptr), 32'd0);

    // Requester 1 with 4.0, then requester 0 with zero at minimum latency
    next_lat = 12; send(1, 32'h4080_0000); drain(100);
    next_lat = 0;  send(0, 32'h0000_0000); drain(100);

    // Pointer at 3 with requesters 0 and 2 pending
    send(2, 32'h3F80_0000); drain(100);
    grant_log.delete();
    send(0, 32'h4110_0000); send(2, 32'h4080_0000); drain(200);
    chk("ptr3_first", 32'(grant_log[0]), 32'd0);
    chk("ptr3_second", 32'(grant_log[1]), 32'd2);

    // Consumer stalls for 10 cycles while another request waits
    next_lat = 3; hold_cnt = 10;
    send(1, 32'h4080_0000);
    step(); step();
    send(3, 32'h3F80_0000);
    drain(200);

    // Watchdog path: unit never raises rdy
    next_stuck = 1; send(2, 32'h4110_0000); drain(200);
    next_stuck = 0;

    // Randomized traffic with random latency, stalls and occasional timeouts
    rr_rand = 1;
    repeat (1500) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 3) == 0) send(i, pick_op());
      next_lat   = $urandom_range(0, 25);
      next_stuck = ($urandom_range(0, 11) == 0);
      step();
    end
    next_stuck = 0;
    drain(2000);
    rr_rand = 0; res_ready = 1'b1;

    // Reset in WAIT after moving the pointer away from 0
    send(2, 32'h4080_0000); drain(100);
    chk("ptr_before_rst", 32'(m_ptr), 32'd3);
    next_stuck = 1; send(1, 32'h4110_0000);
    while (cyc < m_acc + 6 || !m_busy) step();
    rst = 1'b1;
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0;
    m_busy = 0; m_ptr = 0; next_stuck = 0; next_lat = 2;
    for (int i = 0; i < NREQ; i++) send(i, 32'h3F80_0000);
    drain(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
